// File: rtl/cpu_types_pkg.sv
// Shared CPU/memory-side types: word type, RAM handshake states, and the
// default load value returned on a failed access.
package cpu_types_pkg;
  localparam int unsigned WORD_W = 32;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    FREE,
    BUSY,
    ACCESS,
    ERROR
  } ramstate_t;

  localparam word_t ERRWORD_DEFAULT = 32'hBAD1BAD1;
endpackage

// File: rtl/mem_watchdog.sv
// Access watchdog: counts BUSY cycles without ACCESS and flags expiry on the
// TIMEOUT-th such cycle so a stalled RAM access can be force-completed.
module mem_watchdog #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic CLK,
  input  logic nRST,
  input  logic busy,
  input  logic access,
  output logic expired
);
  localparam int unsigned CNT_W = 8;
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] count;

  // Idle cycles hold the counter at zero, so every grant starts fresh.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      count <= '0;
    end else if (!busy) begin
      count <= '0;
    end else if (!access && (count != '1)) begin
      count <= count + CNT_W'(1);
    end
  end

  assign expired = busy && (count == LIMIT);
endmodule

// File: rtl/memory_arbiter.sv
// Serializes icache reads and dcache reads/writes onto one RAM port.
// Build option ARB_ROUND_ROBIN_EN: alternate priority on contention instead
// of fixed data-over-instruction priority.
module memory_arbiter
  import cpu_types_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255,
  parameter word_t       ERRWORD = ERRWORD_DEFAULT
) (
  input  logic      CLK,
  input  logic      nRST,
  input  logic      iREN,
  input  word_t     iaddr,
  input  logic      dREN,
  input  logic      dWEN,
  input  word_t     daddr,
  input  word_t     dstore,
  output logic      iwait,
  output logic      dwait,
  output word_t     iload,
  output word_t     dload,
  output logic      ramREN,
  output logic      ramWEN,
  output word_t     ramaddr,
  output word_t     ramstore,
  input  word_t     ramload,
  input  ramstate_t ramstate,
  output logic      memerr
);
  typedef enum logic [1:0] {
    IDLE,
    IBUSY,
    DBUSY
  } arb_state_t;

  arb_state_t state;
  logic       d_pending;
  logic       busy;
  logic       granted;
  logic       expired;
  logic       done_ok;
  logic       done_err;
  logic       done;
  logic       pick_d;
  word_t      resp;

  mem_watchdog #(
    .TIMEOUT(TIMEOUT)
  ) u_watchdog (
    .CLK    (CLK),
    .nRST   (nRST),
    .busy   (busy),
    .access (ramstate == ACCESS),
    .expired(expired)
  );

`ifdef ARB_ROUND_ROBIN_EN
  logic last_d;

  // Pointer records which side was served last; reset favours data first.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      last_d <= 1'b0;
    end else if (done) begin
      last_d <= (state == DBUSY);
    end
  end

  assign pick_d = d_pending && (!iREN || !last_d);
`else
  assign pick_d = d_pending;
`endif

  // Completion decode: ACCESS beats a coincident error or timeout.
  always_comb begin
    d_pending = dREN | dWEN;
    busy      = (state != IDLE);
    granted   = 1'b0;
    case (state)
      IBUSY:   granted = iREN;
      DBUSY:   granted = d_pending;
      default: granted = 1'b0;
    endcase
    done_ok  = granted && (ramstate == ACCESS);
    done_err = granted && !done_ok && ((ramstate == ERROR) || expired);
    done     = done_ok | done_err;
    resp     = done_ok ? ramload : ERRWORD;
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state  <= IDLE;
      memerr <= 1'b0;
    end else begin
      if (done_err) begin
        memerr <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (pick_d) begin
            state <= DBUSY;
          end else if (iREN) begin
            state <= IBUSY;
          end
        end
        default: begin
          if (!granted || done) begin
            state <= IDLE;
          end
        end
      endcase
    end
  end

  // Cache/RAM side outputs follow the grant combinationally.
  always_comb begin
    iwait    = 1'b1;
    dwait    = 1'b1;
    iload    = '0;
    dload    = '0;
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    case (state)
      IBUSY: begin
        ramREN  = iREN;
        ramaddr = iaddr;
        if (done) begin
          iwait = 1'b0;
          iload = resp;
        end
      end
      DBUSY: begin
        ramWEN   = dWEN;
        ramREN   = dREN & ~dWEN;
        ramaddr  = daddr;
        ramstore = dstore;
        if (done) begin
          dwait = 1'b0;
          dload = resp;
        end
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_memory_arbiter.sv
// Self-checking bench for memory_arbiter: directed scenarios plus randomized
// transactions predicted from RAM latency, error cycle and timeout arithmetic.
module tb_memory_arbiter;
  import cpu_types_pkg::*;

  localparam int TO = 4;
  localparam word_t ERRW = 32'hBAD1BAD1;

  logic      CLK;
  logic      nRST;
  logic      iREN;
  word_t     iaddr;
  logic      dREN;
  logic      dWEN;
  word_t     daddr;
  word_t     dstore;
  logic      iwait;
  logic      dwait;
  word_t     iload;
  word_t     dload;
  logic      ramREN;
  logic      ramWEN;
  word_t     ramaddr;
  word_t     ramstore;
  word_t     ramload;
  ramstate_t ramstate;
  logic      memerr;

  int n_checks = 0;
  int n_fail   = 0;
  bit exp_memerr = 1'b0;
  bit last_d     = 1'b0;

  memory_arbiter #(
    .TIMEOUT(TO),
    .ERRWORD(ERRW)
  ) dut (
    .CLK     (CLK),
    .nRST    (nRST),
    .iREN    (iREN),
    .iaddr   (iaddr),
    .dREN    (dREN),
    .dWEN    (dWEN),
    .daddr   (daddr),
    .dstore  (dstore),
    .iwait   (iwait),
    .dwait   (dwait),
    .iload   (iload),
    .dload   (dload),
    .ramREN  (ramREN),
    .ramWEN  (ramWEN),
    .ramaddr (ramaddr),
    .ramstore(ramstore),
    .ramload (ramload),
    .ramstate(ramstate),
    .memerr  (memerr)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // RAM behaviour for BUSY cycle c: error at err_at, ACCESS after lat wait cycles.
  function automatic ramstate_t ram_at(input int c, input int lat, input int err_at);
    if (err_at != 0 && c == err_at) return ERROR;
    if (c == lat + 1) return ACCESS;
    return BUSY;
  endfunction

  task automatic clear_inputs();
    iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0;
    ramstate = FREE;
  endtask

  task automatic test_reset();
    nRST = 1'b0;
    clear_inputs();
    iaddr = '0; daddr = '0; dstore = '0; ramload = '0;
    repeat (2) @(posedge CLK);
    #1 nRST = 1'b1;
    exp_memerr = 1'b0;
    last_d = 1'b0;
    @(negedge CLK);
    n_checks++;
    if ({iwait, dwait, ramREN, ramWEN, memerr} !== 5'b11000) begin
      n_fail++;
      $display("FAIL reset_ctrl got=%b want=11000", {iwait, dwait, ramREN, ramWEN, memerr});
    end
    n_checks++;
    if ({iload, dload} !== 64'h0) begin
      n_fail++;
      $display("FAIL reset_loads got=%h want=0", {iload, dload});
    end
  endtask

  // One full transaction; completion cycle derived from lat/err_at/TO.
  task automatic do_txn(input bit is_d, input bit wr, input word_t addr, input int lat,
                        input int err_at);
    word_t data, rload, exp_load, exp_il, exp_dl;
    bit    done, exp_done;
    data = $urandom;
    @(posedge CLK);
    #1;
    if (is_d) begin
      dREN = !wr; dWEN = wr; daddr = addr; dstore = data;
    end else begin
      iREN = 1'b1; iaddr = addr;
    end
    ramstate = FREE;
    @(negedge CLK);
    n_checks++;
    if ({iwait, dwait, ramREN, ramWEN, memerr} !== {4'b1100, exp_memerr}) begin
      n_fail++;
      $display("FAIL txn_request_cycle got=%b want=%b", {iwait, dwait, ramREN, ramWEN, memerr},
               {4'b1100, exp_memerr});
    end
    done = 1'b0;
    for (int c = 1; c <= TO + 2 && !done; c++) begin
      @(posedge CLK);
      #1;
      ramstate = ram_at(c, lat, err_at);
      rload = $urandom;
      ramload = rload;
      exp_done = (ramstate == ACCESS) || (ramstate == ERROR) || (c == TO);
      exp_load = (ramstate == ACCESS) ? rload : ERRW;
      exp_il = (exp_done && !is_d) ? exp_load : 32'h0;
      exp_dl = (exp_done && is_d) ? exp_load : 32'h0;
      @(negedge CLK);
      n_checks++;
      if ({iwait, dwait, ramREN, ramWEN, memerr} !==
          {!(exp_done && !is_d), !(exp_done && is_d), !(is_d && wr), is_d && wr, exp_memerr}) begin
        n_fail++;
        $display("FAIL txn_ctrl c=%0d got=%b want=%b", c, {iwait, dwait, ramREN, ramWEN, memerr},
                 {!(exp_done && !is_d), !(exp_done && is_d), !(is_d && wr), is_d && wr, exp_memerr});
      end
      n_checks++;
      if (ramaddr !== addr || (is_d && ramstore !== data)) begin
        n_fail++;
        $display("FAIL txn_addr c=%0d got=%h/%h want=%h/%h", c, ramaddr, ramstore, addr, data);
      end
      n_checks++;
      if (iload !== exp_il || dload !== exp_dl) begin
        n_fail++;
        $display("FAIL txn_load c=%0d got=%h/%h want=%h/%h", c, iload, dload, exp_il, exp_dl);
      end
      if (exp_done) begin
        done = 1'b1;
        if (ramstate != ACCESS) exp_memerr = 1'b1;
        last_d = is_d;
      end
    end
    n_checks++;
    if (!done) begin
      n_fail++;
      $display("FAIL txn_no_completion got=none want=completion by cycle %0d", TO);
    end
    @(posedge CLK);
    #1 clear_inputs();
    @(negedge CLK);
    n_checks++;
    if ({iwait, dwait, ramREN, ramWEN, memerr} !== {4'b1100, exp_memerr}) begin
      n_fail++;
      $display("FAIL txn_after got=%b want=%b", {iwait, dwait, ramREN, ramWEN, memerr},
               {4'b1100, exp_memerr});
    end
  endtask

  task automatic test_iread();
    do_txn(1'b0, 1'b0, 32'h40, 2, 0);
  endtask

  task automatic test_priority();
    bit d_first;
    word_t l1, l2;
    do_txn(1'b1, 1'b0, $urandom, 0, 0);
    d_first = 1'b1;
`ifdef ARB_ROUND_ROBIN_EN
    d_first = !last_d;
`endif
    @(posedge CLK);
    #1 iREN = 1'b1; iaddr = 32'h40; dWEN = 1'b1; daddr = 32'h80; dstore = 32'hCAFE;
    ramstate = FREE;
    @(posedge CLK);
    #1 ramstate = ACCESS; l1 = $urandom; ramload = l1;
    @(negedge CLK);
    n_checks++;
    if (d_first ? ({ramWEN, ramREN, ramaddr, ramstore, dwait, iwait, dload} !==
                   {2'b10, 32'h80, 32'hCAFE, 2'b01, l1})
                : ({ramWEN, ramREN, ramaddr, iwait, dwait, iload} !==
                   {2'b01, 32'h40, 2'b01, l1})) begin
      n_fail++;
      $display("FAIL prio_first d_first=%b got wen=%b ren=%b addr=%h iw=%b dw=%h", d_first,
               ramWEN, ramREN, ramaddr, iwait, dwait);
    end
    @(posedge CLK);
    #1 ramstate = FREE;
    if (d_first) dWEN = 1'b0; else iREN = 1'b0;
    @(negedge CLK);
    n_checks++;
    if ({iwait, dwait, ramREN, ramWEN} !== 4'b1100) begin
      n_fail++;
      $display("FAIL prio_gap got=%b want=1100", {iwait, dwait, ramREN, ramWEN});
    end
    @(posedge CLK);
    #1 ramstate = ACCESS; l2 = $urandom; ramload = l2;
    @(negedge CLK);
    n_checks++;
    if (!d_first ? ({ramWEN, ramREN, ramaddr, dwait, iwait, dload} !==
                    {2'b10, 32'h80, 2'b01, l2})
                 : ({ramWEN, ramREN, ramaddr, iwait, dwait, iload} !==
                    {2'b01, 32'h40, 2'b01, l2})) begin
      n_fail++;
      $display("FAIL prio_second got wen=%b ren=%b addr=%h iw=%b dw=%b", ramWEN, ramREN,
               ramaddr, iwait, dwait);
    end
    last_d = !d_first;
    @(posedge CLK);
    #1 clear_inputs();
  endtask

  task automatic test_timeout();
    do_txn(1'b1, 1'b0, $urandom, 100, 0);
  endtask

  task automatic test_error();
    do_txn(1'b1, 1'b0, $urandom, 5, 1);
    do_txn(1'b0, 1'b0, $urandom, 0, 0);
  endtask

  task automatic test_withdraw();
    word_t l;
    @(posedge CLK);
    #1 dREN = 1'b1; daddr = $urandom; ramstate = FREE;
    @(posedge CLK);
    #1 ramstate = BUSY;
    @(negedge CLK);
    n_checks++;
    if ({ramREN, dwait} !== 2'b11) begin
      n_fail++;
      $display("FAIL withdraw_busy got=%b want=11", {ramREN, dwait});
    end
    @(posedge CLK);
    #1 dREN = 1'b0;
    @(negedge CLK);
    n_checks++;
    if ({ramREN, ramWEN, dwait, iwait} !== 4'b0011) begin
      n_fail++;
      $display("FAIL withdraw_drop got=%b want=0011", {ramREN, ramWEN, dwait, iwait});
    end
    @(posedge CLK);
    #1 dREN = 1'b1;
    @(negedge CLK);
    n_checks++;
    if ({ramREN, dwait} !== 2'b01) begin
      n_fail++;
      $display("FAIL withdraw_idle got=%b want=01", {ramREN, dwait});
    end
    @(posedge CLK);
    #1 ramstate = ACCESS; l = $urandom; ramload = l;
    @(negedge CLK);
    n_checks++;
    if ({ramREN, dwait, dload} !== {2'b10, l}) begin
      n_fail++;
      $display("FAIL withdraw_retry got=%b/%h want=10/%h", {ramREN, dwait}, dload, l);
    end
    last_d = 1'b1;
    @(posedge CLK);
    #1 clear_inputs();
  endtask

  task automatic test_reset_mid();
    @(posedge CLK);
    #1 dWEN = 1'b1; daddr = $urandom; ramstate = FREE;
    @(posedge CLK);
    #1 ramstate = BUSY;
    @(posedge CLK);
    #1 nRST = 1'b0;
    @(negedge CLK);
    n_checks++;
    if ({ramWEN, memerr} !== {1'b1, exp_memerr}) begin
      n_fail++;
      $display("FAIL rstmid_before got=%b want=%b", {ramWEN, memerr}, {1'b1, exp_memerr});
    end
    @(posedge CLK);
    #1 nRST = 1'b1; dWEN = 1'b0; ramstate = FREE;
    exp_memerr = 1'b0;
    last_d = 1'b0;
    @(negedge CLK);
    n_checks++;
    if ({ramREN, ramWEN, dwait, iwait, memerr} !== 5'b00110) begin
      n_fail++;
      $display("FAIL rstmid_after got=%b want=00110", {ramREN, ramWEN, dwait, iwait, memerr});
    end
    // Fresh counter: an unanswered write must time out on exactly the 4th BUSY cycle.
    do_txn(1'b1, 1'b1, $urandom, 100, 0);
  endtask

  task automatic test_random();
    int lat, err_at;
    for (int k = 0; k < 24; k++) begin
      lat = $urandom_range(0, 6);
      err_at = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 5) : 0;
      if (err_at == lat + 1) err_at = 0;
      do_txn(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom, lat, err_at);
    end
  endtask

  initial begin
    test_reset();
    test_iread();
    test_priority();
    test_timeout();
    test_error();
    test_withdraw();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
